nn_input_loader: RTL and testbench
==================================

Name: nn_input_loader

Overview:
- Upstream feeder for NeuralNetwork. Collects a serial 8-bit pixel stream (valid/ready) into the flat numInputs x dataWidth vector NNin, then asserts NNvalid.
- Holds NNin stable until the network reports NNoutValid, then re-arms for the next frame.
- Detects malformed frames using pix_last framing and discards them.

Parameters:
- dataWidth, 16, width of one NN input sample.
- numInputs, 784, samples per frame (28x28).
- pixWidth, 8, width of incoming pixel.
- inShift, 1, right shift applied to each pixel before zero-extension (maps 0..255 to 0..127).
- strictLast, 1, 1 = pix_last must coincide with sample numInputs-1; 0 = pix_last ignored and frames are count-delimited.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- pix_data  in  pixWidth  incoming pixel, raster order.
- pix_valid  in  1  pix_data valid.
- pix_ready  out  1  loader accepts pixel this cycle.
- pix_last  in  1  marks final pixel of a frame; qualified by pix_valid & pix_ready.
- NNin  out  numInputs*dataWidth  frame vector to NeuralNetwork.
- NNvalid  out  1  frame complete and stable; level signal.
- NNoutValid  in  1  NeuralNetwork result ready; releases the frame.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- frame_count  out  16  count of frames delivered (NNvalid rising edges); wraps at 16'hFFFF -> 0.

Behaviour:
- Reset values: pix_ready=0, NNin=0, NNvalid=0, frame_err=0, frame_count=0, idx=0. State=FILL on the first cycle after reset.
- Reset mid-operation discards a partial frame and any held frame. NNvalid drops on the cycle after reset is sampled.
- Accept: a transfer occurs on a cycle where pix_valid & pix_ready.
- Sample conversion: sample = zero-extend(pix_data >> inShift) to dataWidth.
- Sample placement: the sample is written to NNin[idx*dataWidth +: dataWidth]. The first pixel of a frame is idx 0, the least-significant slice.
- idx counter: width clog2(numInputs).
- State FILL: pix_ready=1, NNvalid=0. On a transfer: write the slice and set idx <= idx+1. Special cases:
  - idx==numInputs-1, and pix_last=1 or strictLast=0: write the slice, idx<=0, go to HOLD. NNvalid=1 from the next cycle. frame_count increments on the same edge.
  - idx==numInputs-1, pix_last=0, strictLast=1: frame_err pulse, idx<=0, go to DRAIN.
  - idx<numInputs-1, pix_last=1, strictLast=1: frame_err pulse, idx<=0, stay in FILL. The next pixel starts a new frame.
- State DRAIN: pix_ready=1. Pixels are consumed and discarded. On the transfer carrying pix_last=1, go to FILL. No error pulse.
- State HOLD: pix_ready=0, NNvalid=1, NNin frozen.
  - When NNoutValid is sampled 1: go to FILL. NNvalid=0 and pix_ready=1 from the next cycle.
  - NNoutValid sampled in FILL or DRAIN is ignored.
- Latency: NNvalid rises exactly 1 cycle after the accepting edge of the final pixel. Minimum frame period is numInputs + 1 + (NN latency) + 1 cycles.
- NNin is never cleared between frames. Every slice is overwritten by each complete frame. A discarded partial frame leaves stale slices; NNvalid is never asserted over them.
- Throughput: a back-to-back stream with pix_valid held high is accepted at 1 pixel per clk in FILL.

Decomposition:
- Shared package nn_pkg:
  - default constants NN_DATA_WIDTH=16, NN_NUM_INPUTS=784, NN_PIX_WIDTH=8.
  - enum loader_state_t {FILL, DRAIN, HOLD}.
- One natural sub-module: nn_pix_convert. Combinational shift/zero-extend, parameterised by pixWidth, dataWidth and inShift. Reused later for camera/UART front-ends.
- The FSM, counter and vector register stay in nn_input_loader.

Test Plan:
- Nominal frame: stream 784 pixels, pix_data = idx[7:0], with pix_last on pixel 783 and pix_valid held high.
  - NNvalid=1 exactly 1 cycle after pixel 783 is accepted.
  - NNin[k*16 +: 16] = (k mod 256)>>1 for all k; slice 255 = 16'h007F.
  - frame_count=1.
  - pix_ready=0 while in HOLD.
- Handshake release: hold NNoutValid=0 for 50 cycles, then pulse it for 1 cycle.
  - NNin unchanged across all 50 cycles.
  - NNvalid=0 and pix_ready=1 on the cycle after the pulse.
  - A second frame of pixels all 8'hFF gives every slice = 16'h007F and frame_count=2.
- Short frame: pix_last on pixel 99.
  - frame_err pulses once.
  - NNvalid stays 0.
  - A following valid 784-pixel frame completes normally.
- Long frame: 800 pixels, pix_last only on pixel 799.
  - frame_err pulses once, on pixel 783.
  - Pixels 784..799 are accepted and discarded (DRAIN).
  - Next frame fills from idx 0, verified by NNin[15:0] equal to the first pixel of the new frame.
- Throttled input: random pix_valid gaps (~50% duty).
  - Contents are identical to the nominal case.
  - No pixel is lost or duplicated.
- Reset mid-frame: assert reset for 1 cycle after 400 pixels.
  - All outputs return to their reset values on the next cycle.
  - The next 784-pixel frame completes correctly with frame_count=1.
  - Repeat with reset asserted during HOLD: NNvalid drops the cycle after reset is sampled.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and types for the NN front-end loader.
// Imported by the loader and its pixel converter.
package nn_pkg;

  localparam int NN_DATA_WIDTH = 16;
  localparam int NN_NUM_INPUTS = 784;
  localparam int NN_PIX_WIDTH  = 8;

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    HOLD
  } loader_state_t;

endpackage

// File: rtl/nn_pix_convert.sv
// Pixel to NN sample: right shift then zero-extend.
// Purely combinational; shared with other front-ends.
module nn_pix_convert
  import nn_pkg::*;
#(
  parameter int pixWidth  = NN_PIX_WIDTH,
  parameter int dataWidth = NN_DATA_WIDTH,
  parameter int inShift   = 1
) (
  input  logic [pixWidth-1:0]  pix,
  output logic [dataWidth-1:0] sample
);

  logic [pixWidth-1:0] shifted;

  assign shifted = pix >> inShift;
  assign sample  = dataWidth'(shifted);

endmodule

// File: rtl/nn_input_loader.sv
// Serial pixel stream to flat NN input vector with
// pix_last framing checks and a hold-until-consumed handshake.
module nn_input_loader
  import nn_pkg::*;
#(
  parameter int dataWidth  = NN_DATA_WIDTH,
  parameter int numInputs  = NN_NUM_INPUTS,
  parameter int pixWidth   = NN_PIX_WIDTH,
  parameter int inShift    = 1,
  parameter int strictLast = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [pixWidth-1:0]           pix_data,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic                          pix_last,
  output logic [numInputs*dataWidth-1:0] NNin,
  output logic                          NNvalid,
  input  logic                          NNoutValid,
  output logic                          frame_err,
  output logic [15:0]                   frame_count
);

  localparam int IW = $clog2(numInputs);
  localparam logic [IW-1:0] LAST_IDX = IW'(numInputs - 1);
  localparam bit STRICT = (strictLast != 0);

  loader_state_t state, state_d;
  logic [IW-1:0] idx;
  logic [dataWidth-1:0] sample;
  logic xfer, wr, inc, clr, done, err;

  nn_pix_convert #(
    .pixWidth (pixWidth),
    .dataWidth(dataWidth),
    .inShift  (inShift)
  ) u_conv (
    .pix   (pix_data),
    .sample(sample)
  );

  // Gate with reset so nothing is accepted while reset is held.
  assign pix_ready = (state != HOLD) && !reset;
  assign NNvalid   = (state == HOLD);
  assign xfer      = pix_valid && pix_ready;

  always_comb begin
    state_d = state;
    wr      = 1'b0;
    inc     = 1'b0;
    clr     = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state)
      FILL: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
            clr = 1'b1;
            if (pix_last || !STRICT) begin
              wr      = 1'b1;
              done    = 1'b1;
              state_d = HOLD;
            end else begin
              err     = 1'b1;
              state_d = DRAIN;
            end
          end else if (pix_last && STRICT) begin
            clr = 1'b1;
            err = 1'b1;
          end else begin
            wr  = 1'b1;
            inc = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (xfer && pix_last) state_d = FILL;
      end
      HOLD: begin
        if (NNoutValid) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      idx         <= '0;
      NNin        <= '0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      state     <= state_d;
      frame_err <= err;
      if (clr)
        idx <= '0;
      else if (inc)
        idx <= idx + IW'(1);
      if (wr)
        NNin[idx*dataWidth +: dataWidth] <= sample;
      if (done)
        frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_nn_input_loader.sv
// Directed/random bench for nn_input_loader against a
// frame-level queue model of the pixel stream.
module tb_nn_input_loader;

  localparam int N  = 784;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      pix_data;
  logic            pix_valid;
  logic            pix_ready;
  logic            pix_last;
  logic [N*DW-1:0] NNin;
  logic            NNvalid;
  logic            NNoutValid;
  logic            frame_err;
  logic [15:0]     frame_count;

  nn_input_loader dut (
    .clk        (clk),
    .reset      (reset),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last),
    .NNin       (NNin),
    .NNvalid    (NNvalid),
    .NNoutValid (NNoutValid),
    .frame_err  (frame_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int err_seen = 0;

  // Reference model state
  logic [15:0] exp_slice [N];
  int          q[$];
  bit          discarding;
  int          exp_frames;
  int          exp_errs = 0;
  logic [7:0]  first_pix;

  always @(posedge clk)
    if (frame_err === 1'b1) err_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    discarding = 1'b0;
    exp_frames = 0;
    for (int k = 0; k < N; k++) exp_slice[k] = 16'h0;
  endtask

  // Frame accounting on the accepted stream: exactly N pixels
  // ending in last makes a frame; anything else is an error.
  task automatic model_push(input logic [7:0] d, input logic last);
    if (discarding) begin
      if (last) discarding = 1'b0;
      return;
    end
    q.push_back(int'(d) / 2);
    if (q.size() == N) begin
      if (last) begin
        for (int k = 0; k < N; k++) exp_slice[k] = 16'(q[k]);
        exp_frames++;
      end else begin
        exp_errs++;
        discarding = 1'b1;
      end
      q.delete();
    end else if (last) begin
      exp_errs++;
      q.delete();
    end
  endtask

  function automatic int slice_bad();
    int b = 0;
    for (int k = 0; k < N; k++)
      if (NNin[k*DW +: DW] !== exp_slice[k]) b++;
    return b;
  endfunction

  task automatic chk_vec(input string tag);
    chk(tag, 32'(slice_bad()), 32'd0);
  endtask

  task automatic send(input logic [7:0] d, input logic last,
                      input bit thr);
    int g;
    if (thr) begin
      g = 0;
      while ($urandom_range(1, 0) == 1 && g < 8) begin
        pix_valid = 1'b0;
        @(negedge clk);
        g++;
      end
    end
    pix_data  = d;
    pix_last  = last;
    pix_valid = 1'b1;
    g = 0;
    while (!pix_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!pix_ready) chk("ready_timeout", 32'(pix_ready), 32'd1);
    else model_push(d, last);
    @(negedge clk);
  endtask

  task automatic send_frame(input int n, input int last_at,
                            input int mode, input bit thr);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      if (mode == 0) d = 8'(i);
      else if (mode == 1) d = 8'hFF;
      else d = 8'($urandom);
      if (i == 0) first_pix = d;
      send(d, i == last_at, thr);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_frame();
    NNoutValid = 1'b1;
    @(negedge clk);
    NNoutValid = 1'b0;
  endtask

  initial begin
    int hold_bad;
    reset      = 1'b1;
    pix_data   = '0;
    pix_valid  = 1'b0;
    pix_last   = 1'b0;
    NNoutValid = 1'b0;
    model_reset();
    idle(2);
    chk("rst_ready", 32'(pix_ready), 32'd0);
    chk("rst_valid", 32'(NNvalid), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk_vec("rst_nnin");
    reset = 1'b0;
    idle(1);
    chk("fill_ready", 32'(pix_ready), 32'd1);

    // Nominal frame, valid held high
    send_frame(N - 1, -1, 0, 1'b0);
    chk("valid_early", 32'(NNvalid), 32'd0);
    send(8'(N - 1), 1'b1, 1'b0);
    pix_valid = 1'b0;
    chk("valid_lat1", 32'(NNvalid), 32'd1);
    chk("hold_ready", 32'(pix_ready), 32'd0);
    chk_vec("nom_nnin");
    chk("nom_s255", 32'(NNin[255*DW +: DW]), 32'h7F);
    chk("nom_count", 32'(frame_count), 32'(exp_frames));

    // Hold for 50 cycles with data stable
    hold_bad = 0;
    repeat (50) begin
      @(negedge clk);
      hold_bad += slice_bad();
      if (pix_ready !== 1'b0 || NNvalid !== 1'b1) hold_bad++;
    end
    chk("hold_stable", 32'(hold_bad), 32'd0);
    release_frame();
    chk("rel_valid", 32'(NNvalid), 32'd0);
    chk("rel_ready", 32'(pix_ready), 32'd1);

    send_frame(N, N - 1, 1, 1'b0);
    pix_valid = 1'b0;
    chk_vec("ff_nnin");
    chk("ff_count", 32'(frame_count), 32'(exp_frames));
    release_frame();

    // Short frame
    send_frame(100, 99, 2, 1'b0);
    pix_valid = 1'b0;
    idle(2);
    chk("short_valid", 32'(NNvalid), 32'd0);
    chk("short_errs", 32'(err_seen), 32'(exp_errs));
    send_frame(N, N - 1, 2, 1'b0);
    pix_valid = 1'b0;
    chk_vec("after_short");
    chk("after_short_cnt", 32'(frame_count), 32'(exp_frames));
    release_frame();

    // Long frame
    for (int i = 0; i < 800; i++) begin
      send(8'($urandom), i == 799, 1'b0);
      if (i == 782) chk("long_err_782", 32'(frame_err), 32'd0);
      if (i == 783) chk("long_err_783", 32'(frame_err), 32'd1);
    end
    pix_valid = 1'b0;
    idle(2);
    chk("long_errs", 32'(err_seen), 32'(exp_errs));
    chk("long_valid", 32'(NNvalid), 32'd0);
    send_frame(N, N - 1, 2, 1'b0);
    pix_valid = 1'b0;
    chk("long_first", 32'(NNin[DW-1:0]), 32'(first_pix >> 1));
    chk_vec("after_long");
    chk("after_long_cnt", 32'(frame_count), 32'(exp_frames));
    release_frame();

    // Throttled stream
    send_frame(N, N - 1, 0, 1'b1);
    pix_valid = 1'b0;
    chk("thr_valid", 32'(NNvalid), 32'd1);
    chk_vec("thr_nnin");
    chk("thr_count", 32'(frame_count), 32'(exp_frames));
    release_frame();

    // Reset mid-frame
    send_frame(400, -1, 2, 1'b0);
    pix_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    idle(1);
    chk("mrst_valid", 32'(NNvalid), 32'd0);
    chk("mrst_count", 32'(frame_count), 32'd0);
    chk("mrst_err", 32'(frame_err), 32'd0);
    chk("mrst_ready", 32'(pix_ready), 32'd0);
    chk_vec("mrst_nnin");
    reset = 1'b0;
    idle(1);
    chk("mrst_ready1", 32'(pix_ready), 32'd1);
    send_frame(N, N - 1, 2, 1'b0);
    pix_valid = 1'b0;
    chk_vec("mrst_frame");
    chk("mrst_frame_cnt", 32'(frame_count), 32'd1);

    // Reset during HOLD
    idle(3);
    chk("hrst_pre", 32'(NNvalid), 32'd1);
    reset = 1'b1;
    model_reset();
    idle(1);
    chk("hrst_valid", 32'(NNvalid), 32'd0);
    reset = 1'b0;
    idle(2);
    chk("final_errs", 32'(err_seen), 32'(exp_errs));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
